// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry
// skid buffer (main + skid). The stage supports flush (bubble insertion) and
// keeps a saturating count of stalled output cycles.
//
// Ports
//   clk        rising-edge clock
//   startin_n  asynchronous reset, active-low
//   flush      synchronous kill of every held entry
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle (register output)
//   in_ctrl    control field of the incoming beat
//   in_data    payload of the incoming beat
//   out_valid  downstream beat valid
//   out_ready  downstream accepts the beat this cycle
//   out_ctrl   control field, 0 whenever out_valid=0
//   out_data   payload, holds its last value on a bubble
//   clr_stats  synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              startin_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] out_ctrl_q,   out_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic              in_fire_s;
    logic              out_fire_s;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Handshake qualifiers; in_ready depends only on the skid register.
    always_comb begin
        in_fire_s  = in_valid & ~skid_valid_q;
        out_fire_s = main_valid_q & out_ready;
    end

    // Next-state logic for the main/skid entries; flush overrides everything.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            // Data registers are deliberately left untouched on a flush.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (in_fire_s) begin
                        main_valid_d = 1'b1;
                        main_ctrl_d  = in_ctrl;
                        main_data_d  = in_data;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_fire_s) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire_s) begin
                        skid_valid_d = 1'b1;
                        skid_ctrl_d  = in_ctrl;
                        skid_data_d  = in_data;
                    end else if (out_fire_s) begin
                        main_valid_d = 1'b0;
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only the drain case matters.
                    if (out_fire_s) begin
                        main_ctrl_d  = skid_ctrl_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; collapse to empty to recover.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Registered gated control output and saturating stall counter.
    always_comb begin
        out_ctrl_d = main_valid_d ? main_ctrl_d : {CTRL_W{1'b0}};
        if (clr_stats) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (main_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= {CTRL_W{1'b0}};
            main_data_q  <= {DATA_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= {CTRL_W{1'b0}};
            skid_data_q  <= {DATA_W{1'b0}};
            out_ctrl_q   <= {CTRL_W{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            out_ctrl_q   <= out_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule
